// File: rtl/uart_host_pkg.sv
// Shared types and opcodes for the UART host controller.
package uart_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RUN       = 3'd2,
    ST_DUMP_RD   = 3'd3,
    ST_DUMP_REQ  = 3'd4,
    ST_DUMP_WAIT = 3'd5
  } state_e;

  localparam logic [7:0] OP_LOAD = 8'h01;
  localparam logic [7:0] OP_RUN  = 8'h02;
  localparam logic [7:0] OP_DUMP = 8'h03;

endpackage

// File: rtl/rise_detect.sv
// 1-bit rising-edge detector; the edge output is combinational from the
// current input and the registered previous value.
module rise_detect (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) prev_q <= 1'b0;
    else          prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/uart_host_ctrl.sv
// Command-driven host controller: loads I-memory, runs the CPU for a bounded
// time and streams D-memory back over the UART transmitter.
//
// state        | meaning
// ST_IDLE      | wait for an opcode byte, addresses and run counter held at 0
// ST_LOAD      | each received byte is written to I-memory
// ST_RUN       | CPU out of reset until halt, timeout or host abort
// ST_DUMP_RD   | wait for an idle transmitter, then read D-memory
// ST_DUMP_REQ  | strobe the transmitter with the byte just read
// ST_DUMP_WAIT | wait for the transmitter to take the byte
module uart_host_ctrl
  import uart_host_pkg::*;
#(
  parameter int IMEM_BYTE_ADDR_WIDTH = 6,
  parameter int DMEM_BYTE_ADDR_WIDTH = 6,
  parameter int RUN_CNT_WIDTH        = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            rx_ready_i,
  input  logic [7:0]                      rx_data_i,
  input  logic                            tx_empty_i,
  input  logic                            tx_error_i,
  input  logic                            cpu_halt_i,
  output logic                            cpu_rst_o,
  output logic                            tx_req_o,
  output logic                            imem_ctrl_o,
  output logic                            dmem_ctrl_o,
  output logic                            imem_wr_en_o,
  output logic [IMEM_BYTE_ADDR_WIDTH-1:0] imem_addr_o,
  output logic                            dmem_rd_en_o,
  output logic [DMEM_BYTE_ADDR_WIDTH-1:0] dmem_addr_o,
  output logic                            busy_o,
  output logic                            cmd_error_o
);

  localparam logic [IMEM_BYTE_ADDR_WIDTH-1:0] IMEM_LAST = '1;
  localparam logic [IMEM_BYTE_ADDR_WIDTH-1:0] IMEM_INC  = 1;
  localparam logic [DMEM_BYTE_ADDR_WIDTH-1:0] DMEM_LAST = '1;
  localparam logic [DMEM_BYTE_ADDR_WIDTH-1:0] DMEM_INC  = 1;
  localparam logic [RUN_CNT_WIDTH-1:0]        RUN_LAST  = '1;
  localparam logic [RUN_CNT_WIDTH-1:0]        RUN_INC   = 1;

  state_e                            state_q, state_d;
  logic [IMEM_BYTE_ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
  logic [DMEM_BYTE_ADDR_WIDTH-1:0]   dmem_addr_q, dmem_addr_d;
  logic [RUN_CNT_WIDTH-1:0]          run_cnt_q, run_cnt_d, run_cnt_inc;
  logic                              cmd_error_q, cmd_error_d;
  logic                              tx_req_q;
  logic                              rx_stb;
  logic                              in_dump;

  rise_detect u_rx_rise (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (rx_ready_i),
    .rise_o  (rx_stb)
  );

  assign run_cnt_inc = run_cnt_q + RUN_INC;
  assign in_dump     = (state_q == ST_DUMP_RD) || (state_q == ST_DUMP_REQ) ||
                       (state_q == ST_DUMP_WAIT);

  always_comb begin
    state_d      = state_q;
    imem_addr_d  = imem_addr_q;
    dmem_addr_d  = dmem_addr_q;
    run_cnt_d    = '0;
    cmd_error_d  = cmd_error_q;
    imem_wr_en_o = 1'b0;
    dmem_rd_en_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        imem_addr_d = '0;
        dmem_addr_d = '0;
        if (rx_stb) begin
          case (rx_data_i)
            OP_LOAD: begin state_d = ST_LOAD;    cmd_error_d = 1'b0; end
            OP_RUN:  begin state_d = ST_RUN;     cmd_error_d = 1'b0; end
            OP_DUMP: begin state_d = ST_DUMP_RD; cmd_error_d = 1'b0; end
            default: cmd_error_d = 1'b1;
          endcase
        end
      end
      ST_LOAD: begin
        if (rx_stb) begin
          imem_wr_en_o = 1'b1;
          imem_addr_d  = imem_addr_q + IMEM_INC;
          if (imem_addr_q == IMEM_LAST) state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Compare the incremented count so the longest run is 2**W-1 cycles.
        run_cnt_d = run_cnt_inc;
        if (cpu_halt_i || rx_stb || (run_cnt_inc == RUN_LAST)) begin
          state_d   = ST_IDLE;
          run_cnt_d = '0;
        end
      end
      ST_DUMP_RD: begin
        if (tx_empty_i) begin
          dmem_rd_en_o = 1'b1;
          state_d      = ST_DUMP_REQ;
        end
      end
      ST_DUMP_REQ: begin
        dmem_addr_d = dmem_addr_q + DMEM_INC;
        state_d     = (dmem_addr_q == DMEM_LAST) ? ST_IDLE : ST_DUMP_WAIT;
      end
      ST_DUMP_WAIT: begin
        if (!tx_empty_i) state_d = ST_DUMP_RD;
      end
      default: state_d = ST_IDLE;
    endcase

    // A transmitter fault aborts the dump whatever the state wanted to do.
    if (in_dump && tx_error_i) begin
      state_d      = ST_IDLE;
      cmd_error_d  = 1'b1;
      dmem_rd_en_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      imem_addr_q <= '0;
      dmem_addr_q <= '0;
      run_cnt_q   <= '0;
      cmd_error_q <= 1'b0;
      tx_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_addr_q <= imem_addr_d;
      dmem_addr_q <= dmem_addr_d;
      run_cnt_q   <= run_cnt_d;
      cmd_error_q <= cmd_error_d;
      tx_req_q    <= (state_d == ST_DUMP_REQ);
    end
  end

  assign cpu_rst_o   = (state_q != ST_RUN) || !rst_n_i;
  assign imem_ctrl_o = cpu_rst_o;
  assign dmem_ctrl_o = cpu_rst_o;
  assign busy_o      = (state_q != ST_IDLE);
  assign tx_req_o    = tx_req_q;
  assign cmd_error_o = cmd_error_q;
  assign imem_addr_o = imem_addr_q;
  assign dmem_addr_o = dmem_addr_q;

endmodule

// File: doc/uart_host_ctrl.md
# uart_host_ctrl

Command-driven host controller: the successor to the fixed load-then-dump UART sequencer, parametrised in memory depth and run length. It decodes single-byte commands from the UART receiver to load instruction memory, run the CPU for a bounded time, and stream data memory back over the UART transmitter. It sits between `uart_rx`/`uart_tx` and the I/D-memory muxes, and owns CPU reset.

## Interface
Parameters:
- `IMEM_BYTE_ADDR_WIDTH`, 6, I-memory byte address width; LOAD writes 2**W bytes
- `DMEM_BYTE_ADDR_WIDTH`, 6, D-memory byte address width; DUMP reads 2**W bytes
- `RUN_CNT_WIDTH`, 16, run-timeout counter width; maximum run = 2**W-1 cycles

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `rx_ready` in 1: level, high while the UART RX byte is valid; rising edge = new byte
- `rx_data` in 8: received byte, valid while `rx_ready`=1
- `tx_empty` in 1: transmitter idle, can accept a byte
- `tx_error` in 1: transmitter fault
- `cpu_halt` in 1: CPU reports completion
- `cpu_rst` out 1: CPU reset, active-high
- `tx_req` out 1: one-cycle transmit strobe
- `imem_ctrl`, `dmem_ctrl` out 1: 1 = controller owns the memory port (equal to `cpu_rst`)
- `imem_wr_en` out 1; `imem_addr` out IMEM_BYTE_ADDR_WIDTH
- `dmem_rd_en` out 1; `dmem_addr` out DMEM_BYTE_ADDR_WIDTH
- `busy` out 1: state is not IDLE
- `cmd_error` out 1: sticky; set on bad opcode or TX abort; cleared by the next valid opcode

## Operation
- `rx_stb` = rising edge of `rx_ready` (registered previous value; combinational edge output).
- Opcodes: 0x01 LOAD, 0x02 RUN, 0x03 DUMP. Any other byte in IDLE sets `cmd_error` and leaves the state at IDLE.
- States: IDLE, LOAD, RUN, DUMP_RD, DUMP_REQ, DUMP_WAIT.
- IDLE: on `rx_stb`, decode `rx_data` and clear `cmd_error` if the opcode is valid.
  - 0x01 -> LOAD; 0x02 -> RUN; 0x03 -> DUMP_RD.
  - `imem_addr`, `dmem_addr` and the run counter are held at 0.
- LOAD: `imem_wr_en` = `rx_stb`. `imem_addr` increments after each write. The write at address 2**W-1 returns to IDLE, and the address wraps to 0.
- RUN: `cpu_rst`=0. The run counter increments each cycle. Exit to IDLE on any of the following:
  - `cpu_halt`=1;
  - counter == 2**RUN_CNT_WIDTH-1;
  - `rx_stb` (host abort; the byte is discarded, not decoded).
  - If `cpu_halt` and `rx_stb` occur together, the exit is the same; the byte is still discarded.
- DUMP_RD: wait for `tx_empty`=1, then assert `dmem_rd_en` for 1 cycle -> DUMP_REQ.
- DUMP_REQ: `tx_req`=1 for 1 cycle; `dmem_addr` increments at the end of this cycle.
  - If the address was 2**W-1: -> IDLE (the address wraps to 0).
  - Otherwise -> DUMP_WAIT.
- DUMP_WAIT: wait for `tx_empty`=0 (transmitter accepted the byte) -> DUMP_RD.
- In any DUMP state, `tx_error`=1 -> IDLE and sets `cmd_error`. `tx_error` takes priority over the state's normal transition.
- In LOAD and DUMP states, `rx_stb` is not decoded as a command. In DUMP it is ignored.
- `cpu_rst` = 1 in every state except RUN, and while `rst_n`=0 (combinational OR with `!rst_n`).
- Reset values:
  - state IDLE; `cpu_rst`, `imem_ctrl`, `dmem_ctrl` = 1;
  - `tx_req`, `imem_wr_en`, `dmem_rd_en`, `busy`, `cmd_error` = 0;
  - addresses and counter = 0.
- Asserting `rst_n` in mid-operation aborts immediately. A partially loaded I-memory keeps its contents.

## Timing
- `imem_wr_en` is high in the first clock cycle where `rx_ready` is sampled high after being low. `rx_data` is written that cycle.
- `dmem_rd_en` to `tx_req`: exactly 1 cycle, matching the 1-cycle D-memory read latency.
- `tx_req` to DUMP_RD: at least 2 cycles, depending on the transmitter's `tx_empty` drop.
- RUN lasts at least 1 cycle. `cpu_rst` falls the cycle after the RUN opcode strobe and rises the cycle after the exit condition.
- Back-to-back `rx_stb`: 1 byte per strobe; no internal buffering. A byte arriving mid-transition is handled by the state current in that cycle.
- All outputs are registered, except the following:
  - `imem_wr_en` and `dmem_rd_en` (combinational from state and strobe);
  - `cpu_rst`, `imem_ctrl`, `dmem_ctrl`, `busy` (decoded from state).

## Structure
- Package `uart_host_pkg`: state enum (3-bit) and opcode localparams `OP_LOAD`, `OP_RUN`, `OP_DUMP`.
- Sub-module `rise_detect`: 1-bit rising-edge detector with asynchronous active-low reset. It is instantiated once, for `rx_ready`.
- Top: state register, two address counters, run counter, `cmd_error` flop, `tx_req` flop.

## Test plan
- Reset then LOAD: release `rst_n`, send 0x01 then 64 bytes -> 64 `imem_wr_en` pulses at addresses 0..63, then `busy`=0 and `cpu_rst`=1 throughout.
- RUN halt vs timeout: with RUN_CNT_WIDTH=4 and `cpu_halt` tied low, send 0x02 -> `cpu_rst`=0 for exactly 15 cycles. Repeat with `cpu_halt` pulsed at cycle 5 -> exit after 5.
- DUMP: send 0x03 with a TX model (`tx_empty` drops 1 cycle after `tx_req` and returns 10 cycles later) -> 64 `tx_req` pulses, each 1 cycle after `dmem_rd_en`, addresses 0..63, then IDLE.
- Error paths:
  - send 0x7F -> `cmd_error`=1 and state stays IDLE; then 0x03 -> `cmd_error` clears;
  - assert `tx_error` at byte 10 of a dump -> IDLE and `cmd_error`=1.
- Host abort: send an RX byte (0x03) during RUN -> RUN exits and the byte is not executed; the next 0x03 starts a dump.
- Async reset mid-dump at byte 20 -> all outputs return to reset values within the same cycle. A new DUMP restarts from address 0.
